branch_metric_unit: RTL and testbench

Computes Fano branch metrics for the two hypotheses (info bit 0 / 1) produced by the re-encoding stage. It sits directly downstream of the recovery encoder. It buffers incoming soft channel symbol pairs in a FIFO, which absorbs the encoder's 8-cycle latency. On each rib-valid it pops one symbol pair and emits the best and worst metrics plus the winning bit to the Fano controller.

---
 rtl/bmu_pkg.sv | 29 ++
 rtl/sym_fifo.sv | 45 ++++
 rtl/branch_metric_unit.sv | 151 +++++++++++++++
 tb/tb_branch_metric_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bmu_pkg.sv
// Shared types, default widths and saturation helper for the branch metric unit.
// Optional erasure support is enabled by defining BMU_ERASURE_EN.
package bmu_pkg;

  localparam int unsigned SOFT_W_DEF   = 4;
  localparam int unsigned METRIC_W_DEF = 8;

  typedef logic signed [METRIC_W_DEF-1:0] metric_t;

  typedef struct packed {
`ifdef BMU_ERASURE_EN
    logic [1:0]            erase;
`endif
    logic [SOFT_W_DEF-1:0] s1;
    logic [SOFT_W_DEF-1:0] s0;
  } sym_pair_t;

  // Clamp a wide signed sum into the range of a w-bit signed metric.
  function automatic int sat_metric(input int m, input int unsigned w);
    int hi;
    int lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (m > hi) return hi;
    if (m < lo) return lo;
    return m;
  endfunction

endpackage

// File: rtl/sym_fifo.sv
// First-word-fall-through FIFO with occupancy output; pointers carry an extra wrap bit.
module sym_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}};
  assign o_empty   = r_wptr == r_rptr;
  assign o_level   = r_wptr - r_rptr;
  assign o_data    = r_mem[r_rptr[AW-1:0]];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/branch_metric_unit.sv
// Fano branch metrics for both hypotheses; symbol FIFO absorbs re-encoder latency.
// Define BMU_ERASURE_EN to add per-bit erasure inputs for depunctured streams.
module branch_metric_unit
  import bmu_pkg::*;
#(
  parameter int unsigned SOFT_W     = SOFT_W_DEF,
  parameter int unsigned METRIC_W   = METRIC_W_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BIAS       = 1,
  localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_sym_vld,
  input  logic [2*SOFT_W-1:0]        i_sym,
`ifdef BMU_ERASURE_EN
  input  logic [1:0]                 i_sym_erase,
`endif
  output logic                       o_sym_rdy,
  input  logic                       i_rib_vld,
  input  logic [1:0]                 i_rib_0,
  input  logic [1:0]                 i_rib_1,
  output logic                       o_vld,
  output logic signed [METRIC_W-1:0] o_metric_best,
  output logic signed [METRIC_W-1:0] o_metric_worst,
  output logic                       o_best_bit,
  output logic [LW-1:0]              o_level,
  output logic                       o_underflow
);

  localparam int unsigned TW = SOFT_W + 3;
`ifdef BMU_ERASURE_EN
  localparam int unsigned DW = 2 * SOFT_W + 2;
`else
  localparam int unsigned DW = 2 * SOFT_W;
`endif

  logic [DW-1:0]       w_fifo_din;
  logic [DW-1:0]       w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;

  logic                r_s1_vld;
  logic [2*SOFT_W-1:0] r_s1_sym;
  logic [1:0]          r_s1_rib0;
  logic [1:0]          r_s1_rib1;
  logic [1:0]          r_s1_erase;
  logic [1:0]          w_head_erase;

  logic                       r_vld;
  logic signed [METRIC_W-1:0] r_best;
  logic signed [METRIC_W-1:0] r_worst;
  logic                       r_best_bit;
  logic                       r_underflow;

`ifdef BMU_ERASURE_EN
  assign w_fifo_din   = {i_sym_erase, i_sym};
  assign w_head_erase = w_head[DW-1 -: 2];
`else
  assign w_fifo_din   = i_sym;
  assign w_head_erase = 2'b00;
`endif

  assign o_sym_rdy = ~w_full & ~reset;
  assign w_push    = i_sym_vld & o_sym_rdy;
  assign w_pop     = i_rib_vld & ~w_empty;

  sym_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_sym_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_sym   <= '0;
      r_s1_rib0  <= '0;
      r_s1_rib1  <= '0;
      r_s1_erase <= '0;
    end else begin
      r_s1_vld <= w_pop;
      if (w_pop) begin
        r_s1_sym   <= w_head[2*SOFT_W-1:0];
        r_s1_rib0  <= i_rib_0;
        r_s1_rib1  <= i_rib_1;
        r_s1_erase <= w_head_erase;
      end
    end
  end

  // Extra headroom bits make negation of the most negative soft value exact.
  function automatic logic signed [TW-1:0] soft_term(input logic [SOFT_W-1:0] i_s,
                                                     input logic i_bit, input logic i_er);
    logic signed [TW-1:0] v;
    v = {{3{i_s[SOFT_W-1]}}, i_s};
    if (i_er) return '0;
    return i_bit ? v : -v;
  endfunction

  logic signed [TW-1:0]       w_t00, w_t01, w_t10, w_t11;
  int                         w_sum0, w_sum1;
  logic signed [METRIC_W-1:0] w_m0, w_m1;
  logic                       w_sel1;

  assign w_t00  = soft_term(r_s1_sym[SOFT_W-1:0], r_s1_rib0[0], r_s1_erase[0]);
  assign w_t01  = soft_term(r_s1_sym[2*SOFT_W-1:SOFT_W], r_s1_rib0[1], r_s1_erase[1]);
  assign w_t10  = soft_term(r_s1_sym[SOFT_W-1:0], r_s1_rib1[0], r_s1_erase[0]);
  assign w_t11  = soft_term(r_s1_sym[2*SOFT_W-1:SOFT_W], r_s1_rib1[1], r_s1_erase[1]);
  assign w_sum0 = int'(w_t00) + int'(w_t01) - int'(BIAS);
  assign w_sum1 = int'(w_t10) + int'(w_t11) - int'(BIAS);
  assign w_m0   = METRIC_W'(sat_metric(w_sum0, METRIC_W));
  assign w_m1   = METRIC_W'(sat_metric(w_sum1, METRIC_W));
  assign w_sel1 = w_m1 > w_m0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld       <= 1'b0;
      r_best      <= '0;
      r_worst     <= '0;
      r_best_bit  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_best     <= w_sel1 ? w_m1 : w_m0;
        r_worst    <= w_sel1 ? w_m0 : w_m1;
        r_best_bit <= w_sel1;
      end
      if (i_rib_vld && w_empty) r_underflow <= 1'b1;
    end
  end

  assign o_vld          = r_vld;
  assign o_metric_best  = r_best;
  assign o_metric_worst = r_worst;
  assign o_best_bit     = r_best_bit;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_branch_metric_unit.sv
// Directed bench for branch_metric_unit: an 8-bit-metric and a 4-bit-metric instance share stimulus.
module tb_branch_metric_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       sym_vld;
  logic [7:0] sym;
  logic [1:0] sym_erase;
  logic       rib_vld;
  logic [1:0] rib0, rib1;

  logic              rdy8, vld8, bit8, uf8;
  logic signed [7:0] best8, worst8;
  logic [4:0]        lvl8;
  logic              rdy4, vld4, bit4, uf4;
  logic signed [3:0] best4, worst4;
  logic [4:0]        lvl4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_metric_unit #(.SOFT_W(4), .METRIC_W(8), .FIFO_DEPTH(16), .BIAS(1)) u_dut8 (
    .clk(clk), .reset(reset), .i_sym_vld(sym_vld), .i_sym(sym),
`ifdef BMU_ERASURE_EN
    .i_sym_erase(sym_erase),
`endif
    .o_sym_rdy(rdy8), .i_rib_vld(rib_vld), .i_rib_0(rib0), .i_rib_1(rib1),
    .o_vld(vld8), .o_metric_best(best8), .o_metric_worst(worst8), .o_best_bit(bit8),
    .o_level(lvl8), .o_underflow(uf8)
  );

  branch_metric_unit #(.SOFT_W(4), .METRIC_W(4), .FIFO_DEPTH(16), .BIAS(1)) u_dut4 (
    .clk(clk), .reset(reset), .i_sym_vld(sym_vld), .i_sym(sym),
`ifdef BMU_ERASURE_EN
    .i_sym_erase(sym_erase),
`endif
    .o_sym_rdy(rdy4), .i_rib_vld(rib_vld), .i_rib_0(rib0), .i_rib_1(rib1),
    .o_vld(vld4), .o_metric_best(best4), .o_metric_worst(worst4), .o_best_bit(bit4),
    .o_level(lvl4), .o_underflow(uf4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    sym = d; sym_vld = 1'b1;
    step();
    sym_vld = 1'b0;
  endtask

  task automatic pop(input logic [1:0] r0, input logic [1:0] r1);
    rib0 = r0; rib1 = r1; rib_vld = 1'b1;
    step();
    rib_vld = 1'b0;
  endtask

  task automatic chk_out(input string tag, input int b8, input int w8, input int b4,
                         input int w4, input int bb);
    chk({tag, "_vld8"}, int'(vld8), 1);
    chk({tag, "_vld4"}, int'(vld4), 1);
    chk({tag, "_best8"}, int'(best8), b8);
    chk({tag, "_worst8"}, int'(worst8), w8);
    chk({tag, "_best4"}, int'(best4), b4);
    chk({tag, "_worst4"}, int'(worst4), w4);
    chk({tag, "_bit8"}, int'(bit8), bb);
    chk({tag, "_bit4"}, int'(bit4), bb);
  endtask

  initial begin
    int pidx;
    int sv, m0, m1, eb, ew, ebit;
    bit saw_vld;

    reset = 1'b1; sym_vld = 1'b0; sym = '0; sym_erase = 2'b00;
    rib_vld = 1'b0; rib0 = '0; rib1 = '0;
    step(); step();
    chk("rst_rdy", int'(rdy8), 0);
    chk("rst_level", int'(lvl8), 0);
    chk("rst_vld", int'(vld8), 0);
    chk("rst_uf", int'(uf8), 0);
    chk("rst_best", int'(best8), 0);
    reset = 1'b0;
    step();
    chk("rel_rdy", int'(rdy8), 1);

    // Nominal: {-7, +7}, ribs 01 / 11
    push(8'h97);
    chk("nom_level", int'(lvl8), 1);
    pop(2'b01, 2'b11);
    chk("nom_lat1", int'(vld8), 0);
    chk("nom_level0", int'(lvl8), 0);
    step();
    chk_out("nom", 13, -1, 7, -1, 0);
    step();
    chk("nom_pulse", int'(vld8), 0);
    chk("nom_hold", int'(best8), 13);

    // Tie
    push(8'h00);
    pop(2'b00, 2'b11);
    step();
    chk_out("tie", -1, -1, -1, -1, 0);

    // Saturation
    push(8'h88);
    pop(2'b11, 2'b11);
    step();
    chk_out("satneg", -17, -17, -8, -8, 0);
    push(8'h77);
    pop(2'b00, 2'b11);
    step();
    chk_out("satpos", 13, -15, 7, -8, 1);

    // Push + pop in the same cycle, then back-to-back pop
    push(8'h11);
    sym = 8'h22; sym_vld = 1'b1; rib0 = 2'b00; rib1 = 2'b00; rib_vld = 1'b1;
    step();
    sym_vld = 1'b0;
    chk("pp_level", int'(lvl8), 1);
    rib0 = 2'b11; rib1 = 2'b00;
    step();
    rib_vld = 1'b0;
    chk("pp_level0", int'(lvl8), 0);
    chk_out("bb_a", -3, -3, -3, -3, 0);
    step();
    chk_out("bb_b", 3, -5, 3, -5, 0);
    step();
    chk("bb_end", int'(vld8), 0);

    // Fill to full, attempt an extra push
    for (int i = 0; i < 16; i++) push({4'h0, i[3:0]});
    chk("full_rdy", int'(rdy8), 0);
    chk("full_level", int'(lvl8), 16);
    push(8'hff);
    chk("full_nopush", int'(lvl8), 16);

    // Drain with 16 back-to-back ribs
    pidx = 0;
    rib0 = 2'b01; rib1 = 2'b00;
    for (int k = 0; k < 18; k++) begin
      rib_vld = (k < 16);
      step();
      if (vld8) begin
        if (pidx < 16) begin
          sv = (pidx < 8) ? pidx : pidx - 16;
          m0 = sv - 1;
          m1 = -sv - 1;
          ebit = (m1 > m0) ? 1 : 0;
          eb = ebit ? m1 : m0;
          ew = ebit ? m0 : m1;
          chk($sformatf("drain%0d_best", pidx), int'(best8), eb);
          chk($sformatf("drain%0d_worst", pidx), int'(worst8), ew);
          chk($sformatf("drain%0d_bit", pidx), int'(bit8), ebit);
        end
        pidx++;
      end
    end
    rib_vld = 1'b0;
    chk("drain_pulses", pidx, 16);
    chk("drain_uf", int'(uf8), 0);
    chk("drain_level", int'(lvl8), 0);

    // 17th rib underflows
    saw_vld = 1'b0;
    pop(2'b01, 2'b00);
    for (int k = 0; k < 3; k++) begin
      if (vld8) saw_vld = 1'b1;
      step();
    end
    chk("uf_novld", int'(saw_vld), 0);
    chk("uf_set", int'(uf8), 1);
    chk("uf_set4", int'(uf4), 1);

    // Reset mid-stream
    for (int i = 0; i < 5; i++) push(8'h33);
    chk("mid_level5", int'(lvl8), 5);
    reset = 1'b1;
    step();
    chk("mid_level0", int'(lvl8), 0);
    chk("mid_uf0", int'(uf8), 0);
    chk("mid_rdy0", int'(rdy8), 0);
    reset = 1'b0;
    step();
    chk("mid_rdy1", int'(rdy8), 1);
    pop(2'b00, 2'b00);
    chk("mid_uf1", int'(uf8), 1);

`ifdef BMU_ERASURE_EN
    sym_erase = 2'b01;
    push(8'h58);
    sym_erase = 2'b00;
    pop(2'b10, 2'b10);
    step();
    chk_out("erase", 4, 4, 4, 4, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
